// File: rtl/tlv5618_dual_sched.sv
// tlv5618_dual_sched
// Write scheduler sitting in front of the TLV5618 serial driver. It collects
// independent 12-bit update requests for DAC channels A and B, turns them into
// 16-bit control words {R1, SPD, PWR, R0, D11..D0}, and hands them to the
// driver one at a time with a single-cycle go pulse. When both channels are
// pending it writes B to the DAC buffer first, then writes A together with the
// buffer-to-B update, so both outputs change on the same frame.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ch_a_req / ch_a_data     channel A update pulse and 12-bit code
//   ch_b_req / ch_b_data     channel B update pulse and 12-bit code
//   pwr_down                 level copied into the PWR bit of each word at commit
//   dac_data                 word to driver, held until the next issue
//   dac_convert_en_go        single-cycle start pulse to driver
//   dac_convert_busy         driver busy flag
//   ch_a_ack / ch_b_ack      completion pulses
//   sched_busy               scheduler not idle or a request still pending
//   start_err                pulse: driver did not raise busy in time
module tlv5618_dual_sched #(
    parameter int FAST_MODE  = 1,
    parameter int GAP_CYCLES = 8,
    parameter int START_TMO  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_a_req,
    input  logic [11:0] ch_a_data,
    input  logic        ch_b_req,
    input  logic [11:0] ch_b_data,
    input  logic        pwr_down,
    output logic [15:0] dac_data,
    output logic        dac_convert_en_go,
    input  logic        dac_convert_busy,
    output logic        ch_a_ack,
    output logic        ch_b_ack,
    output logic        sched_busy,
    output logic        start_err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GAP        = 3'd4
    } state_t;

    localparam logic       SPD_BIT  = (FAST_MODE != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] TMO_LAST = 4'(START_TMO - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);

    // Control word layout: {R1, SPD, PWR, R0, code}
    function automatic logic [15:0] make_word(input logic r1, input logic r0,
                                              input logic pd, input logic [11:0] code);
        make_word = {r1, SPD_BIT, pd, r0, code};
    endfunction

    state_t      state_q,  state_d;
    logic        pend_a_q, pend_a_d;
    logic        pend_b_q, pend_b_d;
    logic [11:0] data_a_q, data_a_d;
    logic [11:0] data_b_q, data_b_d;
    logic [15:0] word_q,   word_d;
    logic        go_q,     go_d;
    logic        a_ack_q,  a_ack_d;
    logic        b_ack_q,  b_ack_d;
    logic        err_q,    err_d;
    logic        sbusy_q,  sbusy_d;
    logic [3:0]  tmo_q,    tmo_d;
    logic [7:0]  gap_q,    gap_d;
    logic        pair_q,   pair_d;     // a PAIR job is in flight
    logic        second_q, second_d;   // PAIR buffer word done, A word due after GAP

    // Next-state, job selection and request capture
    always_comb begin
        state_d  = state_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        word_d   = word_q;
        go_d     = 1'b0;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        err_d    = 1'b0;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        pair_d   = pair_q;
        second_d = second_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_a_q && pend_b_q) begin
                    // PAIR: B into the buffer first; pend_a stays set until the A word
                    word_d   = make_word(1'b0, 1'b1, pwr_down, data_b_q);
                    pend_b_d = 1'b0;
                    pair_d   = 1'b1;
                    go_d     = 1'b1;
                    state_d  = ST_ISSUE;
                end else if (pend_b_q) begin
                    word_d   = make_word(1'b0, 1'b0, pwr_down, data_b_q);
                    pend_b_d = 1'b0;
                    go_d     = 1'b1;
                    state_d  = ST_ISSUE;
                end else if (pend_a_q) begin
                    word_d   = make_word(1'b1, 1'b0, pwr_down, data_a_q);
                    pend_a_d = 1'b0;
                    go_d     = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // go is high during this cycle; count clocks since go
                tmo_d   = 4'd1;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (dac_convert_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q >= TMO_LAST) begin
                    // Driver never started: flag it and put the job back for a retry
                    err_d   = 1'b1;
                    gap_d   = 8'd1;
                    state_d = ST_GAP;
                    if (pair_q) begin
                        pend_a_d = 1'b1;
                        pend_b_d = 1'b1;
                        pair_d   = 1'b0;
                    end else if (word_q[15]) begin
                        pend_a_d = 1'b1;
                    end else begin
                        pend_b_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!dac_convert_busy) begin
                    gap_d   = 8'd1;
                    state_d = ST_GAP;
                    if (word_q[15]) begin
                        a_ack_d = 1'b1;
                        b_ack_d = pair_q;
                        pair_d  = 1'b0;
                    end else if (word_q[12]) begin
                        second_d = 1'b1;
                    end else begin
                        b_ack_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    if (second_q) begin
                        // A word picks up the latest data_a and updates B from the buffer
                        word_d   = make_word(1'b1, 1'b0, pwr_down, data_a_q);
                        pend_a_d = 1'b0;
                        second_d = 1'b0;
                        go_d     = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture after commit so a request in the commit cycle re-arms the channel
        if (ch_a_req) begin
            pend_a_d = 1'b1;
            data_a_d = ch_a_data;
        end else begin
            data_a_d = data_a_q;
        end
        if (ch_b_req) begin
            pend_b_d = 1'b1;
            data_b_d = ch_b_data;
        end else begin
            data_b_d = data_b_q;
        end

        sbusy_d = (state_d != ST_IDLE) || pend_a_d || pend_b_d;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            data_a_q <= 12'h000;
            data_b_q <= 12'h000;
            word_q   <= 16'h0000;
            go_q     <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            sbusy_q  <= 1'b0;
            tmo_q    <= 4'd0;
            gap_q    <= 8'd0;
            pair_q   <= 1'b0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            word_q   <= word_d;
            go_q     <= go_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            err_q    <= err_d;
            sbusy_q  <= sbusy_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            pair_q   <= pair_d;
            second_q <= second_d;
        end
    end

    assign dac_data          = word_q;
    assign dac_convert_en_go = go_q;
    assign ch_a_ack          = a_ack_q;
    assign ch_b_ack          = b_ack_q;
    assign sched_busy        = sbusy_q;
    assign start_err         = err_q;

endmodule

// File: tb/tb_tlv5618_dual_sched.sv
// Directed bench for tlv5618_dual_sched with a simple driver busy model:
// busy rises 3 clocks after go and falls 147 clocks after go.
module tb_tlv5618_dual_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch_a_req = 1'b0;
    logic [11:0] ch_a_data = 12'h000;
    logic        ch_b_req = 1'b0;
    logic [11:0] ch_b_data = 12'h000;
    logic        pwr_down = 1'b0;
    logic [15:0] dac_data;
    logic        dac_convert_en_go;
    logic        dac_convert_busy = 1'b0;
    logic        ch_a_ack;
    logic        ch_b_ack;
    logic        sched_busy;
    logic        start_err;

    int checks = 0;
    int errors = 0;

    // Observation counters, updated at every falling edge
    int          cyc = 0;
    int          go_cnt = 0;
    int          a_cnt = 0;
    int          b_cnt = 0;
    int          err_cnt = 0;
    int          bad_go = 0;
    int          last_go_cyc = 0;
    int          last_a_cyc = 0;
    int          last_b_cyc = 0;
    int          last_err_cyc = 0;
    logic [15:0] last_word = 16'h0000;
    logic        busy_en = 1'b1;

    int t0, g, g2, go0, a0, b0, e0;

    tlv5618_dual_sched dut (
        .clk               (clk),
        .rst               (rst),
        .ch_a_req          (ch_a_req),
        .ch_a_data         (ch_a_data),
        .ch_b_req          (ch_b_req),
        .ch_b_data         (ch_b_data),
        .pwr_down          (pwr_down),
        .dac_data          (dac_data),
        .dac_convert_en_go (dac_convert_en_go),
        .dac_convert_busy  (dac_convert_busy),
        .ch_a_ack          (ch_a_ack),
        .ch_b_ack          (ch_b_ack),
        .sched_busy        (sched_busy),
        .start_err         (start_err)
    );

    always #10 clk = ~clk;

    // Event monitor
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dac_convert_en_go === 1'b1) begin
            go_cnt      <= go_cnt + 1;
            last_go_cyc <= cyc + 1;
            last_word   <= dac_data;
            if (dac_convert_busy === 1'b1) bad_go <= bad_go + 1;
        end
        if (ch_a_ack === 1'b1) begin
            a_cnt      <= a_cnt + 1;
            last_a_cyc <= cyc + 1;
        end
        if (ch_b_ack === 1'b1) begin
            b_cnt      <= b_cnt + 1;
            last_b_cyc <= cyc + 1;
        end
        if (start_err === 1'b1) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc + 1;
        end
    end

    // Driver busy model
    initial begin
        forever begin
            @(negedge clk);
            if (busy_en && dac_convert_en_go === 1'b1) begin
                repeat (3) @(negedge clk);
                dac_convert_busy = 1'b1;
                repeat (144) @(negedge clk);
                dac_convert_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state ----
        tick(3);
        chk("rst_data", 32'(dac_data), 32'h0);
        chk("rst_go", 32'(dac_convert_en_go), 32'h0);
        chk("rst_sbusy", 32'(sched_busy), 32'h0);
        rst = 1'b0;
        tick(2);
        chk("rel_acks", 32'({ch_a_ack, ch_b_ack, start_err}), 32'h0);

        // ---- B only: 0x123 -> 0x4123 ----
        go0 = go_cnt; a0 = a_cnt; b0 = b_cnt;
        t0 = cyc;
        ch_b_req = 1'b1; ch_b_data = 12'h123;
        tick(1); ch_b_req = 1'b0;
        tick(1);
        g = t0 + 2;
        chk("b_go_latency", 32'(last_go_cyc), 32'(g));
        chk("b_word", 32'(last_word), 32'h4123);
        tick(20);
        chk("b_sbusy_mid", 32'(sched_busy), 32'h1);
        chk("b_data_hold", 32'(dac_data), 32'h4123);
        tick(128);
        chk("b_ack_cyc", 32'(last_b_cyc), 32'(g + 148));
        chk("b_ack_cnt", 32'(b_cnt - b0), 32'd1);
        chk("b_go_cnt", 32'(go_cnt - go0), 32'd1);
        chk("b_no_a_ack", 32'(a_cnt - a0), 32'd0);
        tick(7);
        chk("b_sbusy_gap", 32'(sched_busy), 32'h1);
        tick(1);
        chk("b_sbusy_idle", 32'(sched_busy), 32'h0);

        // ---- Pair: A 0xABC + B 0x456 -> 0x5456 then 0xCABC ----
        go0 = go_cnt; a0 = a_cnt; b0 = b_cnt;
        t0 = cyc;
        ch_a_req = 1'b1; ch_a_data = 12'hABC;
        ch_b_req = 1'b1; ch_b_data = 12'h456;
        tick(1); ch_a_req = 1'b0; ch_b_req = 1'b0;
        tick(1);
        g = t0 + 2;
        chk("pair_go1_cyc", 32'(last_go_cyc), 32'(g));
        chk("pair_word1", 32'(last_word), 32'h5456);
        tick(148);
        chk("pair_no_ack1", 32'((a_cnt - a0) + (b_cnt - b0)), 32'd0);
        tick(8);
        g2 = g + 156;
        chk("pair_go2_cyc", 32'(last_go_cyc), 32'(g2));
        chk("pair_word2", 32'(last_word), 32'hCABC);
        tick(148);
        chk("pair_a_ack_cyc", 32'(last_a_cyc), 32'(g2 + 148));
        chk("pair_b_ack_cyc", 32'(last_b_cyc), 32'(g2 + 148));
        chk("pair_ack_cnt", 32'({16'(a_cnt - a0), 16'(b_cnt - b0)}), 32'h0001_0001);
        chk("pair_go_cnt", 32'(go_cnt - go0), 32'd2);
        tick(8);
        chk("pair_idle", 32'(sched_busy), 32'h0);

        // ---- Overwrite during a B frame: A 0x001 then 0x7FF -> one 0xC7FF ----
        go0 = go_cnt; a0 = a_cnt; b0 = b_cnt;
        t0 = cyc;
        ch_b_req = 1'b1; ch_b_data = 12'h0AA;
        tick(1); ch_b_req = 1'b0;
        tick(1);
        g = t0 + 2;
        chk("ovw_b_word", 32'(last_word), 32'h40AA);
        tick(50);
        ch_a_req = 1'b1; ch_a_data = 12'h001;
        tick(1); ch_a_req = 1'b0;
        tick(10);
        ch_a_req = 1'b1; ch_a_data = 12'h7FF;
        tick(1); ch_a_req = 1'b0;
        tick(86);
        chk("ovw_b_ack_cyc", 32'(last_b_cyc), 32'(g + 148));
        tick(9);
        g2 = g + 157;
        chk("ovw_a_go_cyc", 32'(last_go_cyc), 32'(g2));
        chk("ovw_a_word", 32'(last_word), 32'hC7FF);
        tick(148);
        chk("ovw_a_ack_cyc", 32'(last_a_cyc), 32'(g2 + 148));
        chk("ovw_ack_cnt", 32'({16'(a_cnt - a0), 16'(b_cnt - b0)}), 32'h0001_0001);
        chk("ovw_go_cnt", 32'(go_cnt - go0), 32'd2);
        tick(8);

        // ---- B request during A frame: A 0x200 then B 0x010 ----
        go0 = go_cnt; a0 = a_cnt; b0 = b_cnt;
        t0 = cyc;
        ch_a_req = 1'b1; ch_a_data = 12'h200;
        tick(1); ch_a_req = 1'b0;
        tick(1);
        g = t0 + 2;
        chk("mid_a_word", 32'(last_word), 32'hC200);
        tick(50);
        ch_b_req = 1'b1; ch_b_data = 12'h010;
        tick(1); ch_b_req = 1'b0;
        tick(97);
        chk("mid_a_ack_cyc", 32'(last_a_cyc), 32'(g + 148));
        chk("mid_b_not_yet", 32'(b_cnt - b0), 32'd0);
        tick(9);
        g2 = g + 157;
        chk("mid_b_go_cyc", 32'(last_go_cyc), 32'(g2));
        chk("mid_b_word", 32'(last_word), 32'h4010);
        tick(148);
        chk("mid_b_ack_cyc", 32'(last_b_cyc), 32'(g2 + 148));
        chk("mid_ack_cnt", 32'({16'(a_cnt - a0), 16'(b_cnt - b0)}), 32'h0001_0001);
        tick(8);

        // ---- Start timeout with pwr_down=1: 0x6123 retried ----
        go0 = go_cnt; a0 = a_cnt; b0 = b_cnt; e0 = err_cnt;
        busy_en = 1'b0;
        pwr_down = 1'b1;
        t0 = cyc;
        ch_b_req = 1'b1; ch_b_data = 12'h123;
        tick(1); ch_b_req = 1'b0;
        tick(1);
        g = t0 + 2;
        chk("tmo_word", 32'(last_word), 32'h6123);
        tick(4);
        chk("tmo_err_pulse", 32'(start_err), 32'h1);
        chk("tmo_err_cyc", 32'(last_err_cyc), 32'(g + 4));
        busy_en = 1'b1;
        tick(1);
        chk("tmo_err_single", 32'(start_err), 32'h0);
        tick(8);
        chk("tmo_retry_cyc", 32'(last_go_cyc), 32'(g + 13));
        chk("tmo_retry_word", 32'(last_word), 32'h6123);
        chk("tmo_no_ack", 32'(b_cnt - b0), 32'd0);
        tick(148);
        chk("tmo_b_ack_cyc", 32'(last_b_cyc), 32'(g + 161));
        chk("tmo_counts", 32'({8'(go_cnt - go0), 8'(err_cnt - e0), 8'(a_cnt - a0), 8'(b_cnt - b0)}),
            32'h02_01_00_01);
        tick(8);
        pwr_down = 1'b0;

        // ---- Reset during WAIT_DONE ----
        go0 = go_cnt; a0 = a_cnt; b0 = b_cnt;
        t0 = cyc;
        ch_a_req = 1'b1; ch_a_data = 12'h555;
        tick(1); ch_a_req = 1'b0;
        tick(1);
        chk("rstm_word", 32'(last_word), 32'hC555);
        tick(20);
        chk("rstm_in_frame", 32'({dac_convert_busy, sched_busy}), 32'h3);
        rst = 1'b1;
        #1;
        chk("rstm_outputs", 32'({dac_data, dac_convert_en_go, ch_a_ack, ch_b_ack, sched_busy, start_err}),
            32'h0);
        tick(2);
        rst = 1'b0;
        tick(150);
        chk("rstm_no_ack", 32'({16'(a_cnt - a0), 16'(b_cnt - b0)}), 32'h0);
        chk("rstm_no_go", 32'(go_cnt - go0), 32'd1);
        chk("rstm_idle", 32'({dac_data, sched_busy}), 32'h0);

        chk("no_go_while_busy", 32'(bad_go), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlv5618_dual_sched.md
Name: tlv5618_dual_sched

Overview:
- Write scheduler in front of the TLV5618 serial driver.
- Accepts independent 12-bit update requests for DAC channels A and B and builds the 16-bit control words (R1|SPD|PWR|R0|D11..D0).
- Issues them to the driver with a one-cycle go pulse and tracks the driver's busy flag.
- When A and B are both pending, it sequences them so both outputs change on the same frame: B goes to BUFFER, then A is written together with the B-from-buffer update.

Parameters:
FAST_MODE, 1, value driven on SPD bit (D14) of every word.
GAP_CYCLES, 8, idle clocks after driver busy falls before the next go (CS high time plus settling); range 1..255.
START_TMO, 4, clocks allowed between go and driver busy rising before a start error is flagged; range 2..15.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-high reset
ch_a_req  input  1  single-cycle pulse: update channel A
ch_a_data  input  12  channel A code, sampled when ch_a_req=1
ch_b_req  input  1  single-cycle pulse: update channel B
ch_b_data  input  12  channel B code, sampled when ch_b_req=1
pwr_down  input  1  level, driven on PWR bit (D13) of every word
dac_data  output  16  word to driver, stable from go until busy falls
dac_convert_en_go  output  1  single-cycle start pulse to driver
dac_convert_busy  input  1  driver busy flag
ch_a_ack  output  1  pulse: channel A word completed
ch_b_ack  output  1  pulse: channel B word completed (standalone or paired)
sched_busy  output  1  high in any state other than IDLE, or while any request is pending
start_err  output  1  pulse: driver busy not seen within START_TMO

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high. All state is cleared on rst.
- Reset values: dac_data=0, go=0, both acks=0, start_err=0, sched_busy=0, pend_a=pend_b=0, state=IDLE.
- Request capture: ch_x_req sets pend_x and loads data_x.
  - A req while pend_x is already set overwrites data_x (latest value wins); only one ack is produced.
  - A req in the same cycle the word is committed for that channel sets pend_x again for a later frame.
  - The committed copy is not altered.
- Word encoding: {R1, FAST_MODE, pwr_down, R0, data}. pwr_down is sampled at commit.
  - B only: R1R0=00.
  - B to buffer: 01.
  - A (and update B from buffer): 10.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE: choose the job, then go to ISSUE.
  - pend_a&pend_b: PAIR job; first word B with R=01, clear pend_b.
  - pend_b only: word B with R=00, clear pend_b.
  - pend_a only: word A with R=10, clear pend_a. The buffer still holds the last B value, so B is re-latched unchanged.
- ISSUE: drive dac_data; go=1 for exactly one cycle; go to WAIT_START.
- WAIT_START: wait for busy=1, then go to WAIT_DONE.
  - If busy is still 0 after START_TMO clocks: pulse start_err and go to GAP.
  - No ack is issued, and the job's pend bits are restored so the job is retried.
- WAIT_DONE: on busy 1->0, ack and go to GAP.
  - B word (R=00): pulse ch_b_ack.
  - PAIR first word (R=01): no ack; remember that the second word is due.
  - A word: pulse ch_a_ack; if it is the PAIR second word, also pulse ch_b_ack in the same cycle.
- GAP: count GAP_CYCLES.
  - If the PAIR second word is due: load the A word (R=10, clear pend_a, using the current data_a) and go to ISSUE.
  - Otherwise go to IDLE.
- Latency: idle, pend_b only → go appears 2 clocks after ch_b_req.
- Frame length is set by the driver (~36 driver ticks × 4 clk ≈ 144 clk). The scheduler never assumes a fixed length and relies only on busy.
- dac_data holds its value until the next ISSUE. go is never asserted while busy=1.
- No starvation: pend_a during a standalone B frame is served next. A PAIR is not broken by a new req.
- Reset mid-frame: scheduler returns to IDLE immediately. Completion of an in-flight driver frame is not tracked and produces no ack.

Test Plan:
- B only: ch_b_req with 0x123; busy model high 3..146 clk after go → dac_data=0x4123 (FAST_MODE=1, pwr_down=0), one go pulse, ch_b_ack 1 clk after busy falls, sched_busy low GAP_CYCLES later.
- Pair: ch_a_req 0xABC and ch_b_req 0x456 in the same cycle → words 0x5456 then 0xCABC, go pulses separated by ≥ frame+8 clk, ch_a_ack and ch_b_ack in the same cycle after the second frame, no ack after the first.
- Overwrite: ch_a_req 0x001, then ch_a_req 0x7FF before commit → single word 0xC7FF, one ch_a_ack.
- Request during frame: ch_b_req 0x010 mid-frame of A word 0x200 → A completes with ack, then after GAP a B word 0x4010 and ch_b_ack.
- Start timeout: busy model stuck at 0 → start_err pulses 4 clk after go, same word re-issued after 8 gap clocks; pwr_down=1 → bit13 set (e.g. 0x6123).
- Reset: assert rst during WAIT_DONE → all outputs 0 in the same cycle, state IDLE, pending cleared, no ack after release.
